// File: rtl/ece2300_test_pkg.sv
// Shared types and LFSR helper for the lab stream test utilities.
// Imported by the checker, the stall LFSR and the matching stream source.
package ece2300_test_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE,
    TIMEOUT
  } checker_state_t;

  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 (bit positions 15,13,12,10)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ece2300_lfsr16.sv
// 16-bit Fibonacci LFSR with load-on-reset seed and step enable.
// Shared by the stream checker and the stream source.
module ece2300_lfsr16
  import ece2300_test_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= seed;
    end else if (en) begin
      out <= lfsr_next(out);
    end
  end

endmodule

// File: rtl/ece2300_stream_checker.sv
// Val/rdy test sink: preloaded expected messages with care masks,
// pseudo-random backpressure, in-order compare and status reporting.
module ece2300_stream_checker
  import ece2300_test_pkg::*;
#(
  parameter int          p_nbits      = 32,
  parameter int          p_max_msgs   = 64,
  parameter int          p_timeout    = 10000,
  parameter int          p_stall_mode = 0,
  parameter int          p_stall_pct  = 50,
  parameter logic [15:0] p_seed       = 16'hbeef
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [p_nbits-1:0]            load_msg,
  input  logic [p_nbits-1:0]            load_mask,
  input  logic                          start,
  input  logic                          val,
  output logic                          rdy,
  input  logic [p_nbits-1:0]            msg,
  output logic                          done,
  output logic                          timeout,
  output logic                          overflow,
  output logic [$clog2(p_max_msgs):0]   num_msgs,
  output logic [$clog2(p_max_msgs):0]   num_errs,
  output logic [$clog2(p_max_msgs)-1:0] err_idx,
  output logic [p_nbits-1:0]            err_msg
);

  localparam int AW = $clog2(p_max_msgs);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(p_timeout + 1);

  typedef struct packed {
    logic [p_nbits-1:0] msg;
    logic [p_nbits-1:0] mask;
  } entry_t;

  entry_t mem [p_max_msgs];

  checker_state_t    state;
  checker_state_t    state_n;
  logic [CW-1:0]     count;
  logic [TW-1:0]     cyc;
  logic [LFSR_W-1:0] lfsr;
  logic [6:0]        l7;
  logic [6:0]        lmod;
  logic              lfsr_unused;
  logic              in_run;
  logic              stall;
  logic              xfer;
  logic              full;
  logic              wr;
  logic              last;
  logic              expire;
  logic              mismatch;
  entry_t            cur;

  ece2300_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (in_run),
    .seed  (p_seed),
    .out   (lfsr)
  );

  assign in_run      = (state == RUN);
  assign l7          = lfsr[6:0];
  assign lfsr_unused = ^lfsr[LFSR_W-1:7];
  assign lmod        = (l7 >= 7'd100) ? l7 - 7'd100 : l7;
  assign stall       = lmod < 7'(p_stall_pct);
  assign rdy         = in_run &&
                       ((p_stall_mode == 0) || !stall);
  assign xfer        = val && rdy;
  assign full        = (count == CW'(p_max_msgs));
  assign wr          = (state == LOAD) && load_en && !full;
  assign cur         = mem[num_msgs[AW-1:0]];
  assign last        = (num_msgs == count - 1'b1);
  assign expire      = (cyc == TW'(p_timeout - 1));
  assign mismatch    = |((msg ^ cur.msg) & cur.mask);
  assign done        = (state == DONE);
  assign timeout     = (state == TIMEOUT);

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD: begin
        // an empty list with no same-cycle load has nothing to wait for
        if (start) begin
          state_n = (count == '0 && !wr) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer && last) begin
          state_n = DONE;
        end else if (expire) begin
          state_n = TIMEOUT;
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      count    <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
      num_msgs <= '0;
      num_errs <= '0;
      err_idx  <= '0;
      err_msg  <= '0;
    end else begin
      state <= state_n;
      if (wr) begin
        count <= count + 1'b1;
      end
      if ((state == LOAD) && load_en && full) begin
        overflow <= 1'b1;
      end
      if (in_run) begin
        cyc <= cyc + 1'b1;
      end
      if (xfer) begin
        num_msgs <= num_msgs + 1'b1;
        if (mismatch) begin
          num_errs <= num_errs + 1'b1;
          if (num_errs == '0) begin
            err_idx <= num_msgs[AW-1:0];
            err_msg <= msg;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[count[AW-1:0]] <= {load_msg, load_mask};
    end
  end

endmodule

// File: tb/tb_ece2300_stream_checker.sv
// Scoreboard bench: A = no stalls, depth 4, timeout 20;
// B = 50% pseudo-random stalls, default depth and timeout.
module tb_ece2300_stream_checker;

  typedef struct {
    int nm;
    int ne;
  } exp_t;

  logic        clk = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  logic        a_reset, a_load_en, a_start, a_val;
  logic [31:0] a_load_msg, a_load_mask, a_msg, a_err_msg;
  logic        a_rdy, a_done, a_timeout, a_overflow;
  logic [2:0]  a_num_msgs, a_num_errs;
  logic [1:0]  a_err_idx;

  logic        b_reset, b_load_en, b_start, b_val;
  logic [31:0] b_load_msg, b_load_mask, b_msg, b_err_msg;
  logic        b_rdy, b_done, b_timeout, b_overflow;
  logic [6:0]  b_num_msgs, b_num_errs;
  logic [5:0]  b_err_idx;

  always #5 clk = ~clk;

  ece2300_stream_checker #(
    .p_nbits(32), .p_max_msgs(4), .p_timeout(20),
    .p_stall_mode(0), .p_stall_pct(50), .p_seed(16'hbeef)
  ) dut_a (
    .clk(clk), .reset(a_reset), .load_en(a_load_en),
    .load_msg(a_load_msg), .load_mask(a_load_mask),
    .start(a_start), .val(a_val), .rdy(a_rdy), .msg(a_msg),
    .done(a_done), .timeout(a_timeout), .overflow(a_overflow),
    .num_msgs(a_num_msgs), .num_errs(a_num_errs),
    .err_idx(a_err_idx), .err_msg(a_err_msg)
  );

  ece2300_stream_checker #(
    .p_nbits(32), .p_max_msgs(64), .p_timeout(10000),
    .p_stall_mode(1), .p_stall_pct(50), .p_seed(16'hbeef)
  ) dut_b (
    .clk(clk), .reset(b_reset), .load_en(b_load_en),
    .load_msg(b_load_msg), .load_mask(b_load_mask),
    .start(b_start), .val(b_val), .rdy(b_rdy), .msg(b_msg),
    .done(b_done), .timeout(b_timeout), .overflow(b_overflow),
    .num_msgs(b_num_msgs), .num_errs(b_num_errs),
    .err_idx(b_err_idx), .err_msg(b_err_msg)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // monitors: a transfer seen mid-cycle is scored after the next edge
  initial begin
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_xfer: unexpected, num_msgs=%0d", a_num_msgs);
        end else begin
          e = qa.pop_front();
          chk("a_num_msgs", 32'(a_num_msgs), e.nm);
          chk("a_num_errs", 32'(a_num_errs), e.ne);
        end
      end
      pend = a_val && a_rdy && !a_reset;
    end
  end

  initial begin
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_xfer: unexpected, num_msgs=%0d", b_num_msgs);
        end else begin
          e = qb.pop_front();
          chk("b_num_msgs", 32'(b_num_msgs), e.nm);
          chk("b_num_errs", 32'(b_num_errs), e.ne);
        end
      end
      pend = b_val && b_rdy && !b_reset;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic a_idle();
    a_load_en = 1'b0;
    a_start   = 1'b0;
    a_val     = 1'b0;
  endtask

  task automatic a_rst();
    a_idle();
    a_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0;
  endtask

  task automatic a_load(input logic [31:0] m, input logic [31:0] mk,
                        input bit st);
    a_load_en   = 1'b1;
    a_load_msg  = m;
    a_load_mask = mk;
    a_start     = st;
    @(posedge clk); #1;
    a_load_en = 1'b0;
    a_start   = 1'b0;
  endtask

  task automatic a_go();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [31:0] m, input int nm,
                        input int ne);
    a_val = 1'b1;
    a_msg = m;
    qa.push_back('{nm, ne});
    @(posedge clk); #1;
  endtask

  task automatic a_drain();
    a_val = 1'b0;
    @(negedge clk); #1;
    chk("a_queue_empty", 32'(qa.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic a_zero(input string tag);
    chk({tag, "_rdy"}, 32'(a_rdy), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
    chk({tag, "_timeout"}, 32'(a_timeout), 0);
    chk({tag, "_overflow"}, 32'(a_overflow), 0);
    chk({tag, "_num_msgs"}, 32'(a_num_msgs), 0);
    chk({tag, "_num_errs"}, 32'(a_num_errs), 0);
    chk({tag, "_err_idx"}, 32'(a_err_idx), 0);
    chk({tag, "_err_msg"}, a_err_msg, 0);
  endtask

  initial begin
    logic [15:0] s;
    int          acc;
    int          ncyc;
    int          stalls;
    bit          er;

    a_reset = 1'b1; b_reset = 1'b1;
    a_idle();
    a_load_msg = '0; a_load_mask = '0; a_msg = '0;
    b_load_en = 1'b0; b_start = 1'b0; b_val = 1'b0;
    b_load_msg = '0; b_load_mask = '0; b_msg = '0;
    repeat (2) @(posedge clk);
    #1;
    a_zero("rst");
    chk("b_rst_rdy", 32'(b_rdy), 0);
    chk("b_rst_num_msgs", 32'(b_num_msgs), 0);
    a_reset = 1'b0; b_reset = 1'b0;

    // back-to-back, all match; start shares the last load cycle
    a_load(1, '1, 0); a_load(2, '1, 0);
    a_load(3, '1, 0); a_load(4, '1, 1);
    chk("t1_rdy_run", 32'(a_rdy), 1);
    a_send(1, 1, 0); a_send(2, 2, 0);
    a_send(3, 3, 0); a_send(4, 4, 0);
    chk("t1_done", 32'(a_done), 1);
    chk("t1_rdy_done", 32'(a_rdy), 0);
    chk("t1_timeout", 32'(a_timeout), 0);
    a_msg = 5;
    @(posedge clk); #1;
    a_drain();
    chk("t1_num_msgs", 32'(a_num_msgs), 4);

    // third message wrong
    a_rst();
    a_load(1, '1, 0); a_load(2, '1, 0);
    a_load(3, '1, 0); a_load(4, '1, 1);
    a_send(1, 1, 0); a_send(2, 2, 0);
    a_send(7, 3, 1); a_send(4, 4, 1);
    chk("t2_done", 32'(a_done), 1);
    chk("t2_err_idx", 32'(a_err_idx), 2);
    chk("t2_err_msg", a_err_msg, 32'h7);
    a_drain();

    // masking: don't-care bits ignored, care bits checked
    a_rst();
    a_load(32'hAB00, 32'hFF00, 0);
    a_load(32'h00F0, 32'h00F0, 1);
    a_send(32'hABCD, 1, 0);
    a_send(32'h0010, 2, 1);
    chk("t3_done", 32'(a_done), 1);
    chk("t3_err_idx", 32'(a_err_idx), 1);
    chk("t3_err_msg", a_err_msg, 32'h10);
    a_drain();

    // timeout after 20 RUN cycles with one of two sent
    a_rst();
    a_load(1, '1, 0); a_load(2, '1, 1);
    a_send(1, 1, 0);
    a_val = 1'b0;
    repeat (18) begin @(posedge clk); #1; end
    chk("t4_timeout_c19", 32'(a_timeout), 0);
    @(posedge clk); #1;
    chk("t4_timeout_c20", 32'(a_timeout), 1);
    chk("t4_done", 32'(a_done), 0);
    chk("t4_rdy", 32'(a_rdy), 0);
    chk("t4_num_msgs", 32'(a_num_msgs), 1);
    a_drain();

    // transfer in the expiring cycle still counts
    a_rst();
    a_load(1, '1, 0); a_load(2, '1, 0); a_load(3, '1, 1);
    a_send(1, 1, 0);
    a_val = 1'b0;
    repeat (18) begin @(posedge clk); #1; end
    a_send(2, 2, 0);
    chk("t4b_timeout", 32'(a_timeout), 1);
    chk("t4b_done", 32'(a_done), 0);
    a_drain();
    chk("t4b_num_msgs", 32'(a_num_msgs), 2);

    // overflow: fifth load dropped, exactly four entries run
    a_rst();
    a_load(1, '1, 0); a_load(2, '1, 0);
    a_load(3, '1, 0); a_load(4, '1, 0);
    chk("t5_ovf_at4", 32'(a_overflow), 0);
    a_load(5, '1, 0);
    chk("t5_ovf_at5", 32'(a_overflow), 1);
    a_go();
    a_send(1, 1, 0); a_send(2, 2, 0);
    a_send(3, 3, 0); a_send(4, 4, 0);
    chk("t5_done", 32'(a_done), 1);
    chk("t5_ovf_sticky", 32'(a_overflow), 1);
    a_drain();

    // reset mid-RUN after an error, then empty start
    a_rst();
    a_load(1, '1, 0); a_load(2, '1, 1);
    a_send(9, 1, 1);
    a_drain();
    chk("t6_errs_pre", 32'(a_num_errs), 1);
    chk("t6_errmsg_pre", a_err_msg, 32'h9);
    a_rst();
    a_zero("t6");
    a_go();
    chk("t6_empty_done", 32'(a_done), 1);

    // B: 16 messages, val held, rdy follows the seeded LFSR
    for (int i = 0; i < 16; i++) begin
      b_load_en   = 1'b1;
      b_load_msg  = 32'h100 + 32'(i);
      b_load_mask = '1;
      b_start     = (i == 15);
      @(posedge clk); #1;
    end
    b_load_en = 1'b0;
    b_start   = 1'b0;
    s = 16'hbeef;
    acc = 0;
    ncyc = 0;
    stalls = 0;
    b_val = 1'b1;
    b_msg = 32'h100;
    qb.push_back('{1, 0});
    while (acc < 16 && ncyc < 200) begin
      er = (int'(s[6:0]) % 100) >= 50;
      chk("b_rdy", 32'(b_rdy), 32'(er));
      if (!er) stalls++;
      s = step(s);
      @(posedge clk); #1;
      ncyc++;
      if (er) begin
        acc++;
        if (acc < 16) begin
          b_msg = 32'h100 + 32'(acc);
          qb.push_back('{acc + 1, 0});
        end
      end
    end
    n_cmp++;
    if (acc < 16) begin
      n_bad++;
      $display("FAIL b_bound: accepted %0d want 16", acc);
    end
    b_val = 1'b0;
    $display("stream B: %0d stall cycles in %0d", stalls, ncyc);
    chk("b_done", 32'(b_done), 1);
    chk("b_num_msgs", 32'(b_num_msgs), 16);
    chk("b_num_errs", 32'(b_num_errs), 0);
    chk("b_rdy_done", 32'(b_rdy), 0);
    @(negedge clk); #1;
    chk("b_queue_empty", 32'(qb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
